// File: rtl/grom_io_pkg.sv
// rtl/grom_io_pkg.sv - shared IO register offsets, bit positions and debounce states
package grom_io_pkg;

  // IO register offsets, decoded from addr[0]
  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_EVENTS = 1'b1;

  // STATUS: debounced levels in the low bits, any-flag summary on top
  localparam int STATUS_LEVEL_LSB = 0;
  localparam int STATUS_IRQ_BIT   = 7;

  // EVENTS: press flags low nibble, release flags high nibble
  localparam int EVENTS_PRESS_LSB = 0;
  localparam int EVENTS_REL_LSB   = 4;

  // Per-key debounce FSM encoding
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/grom_key_input_if.sv
// rtl/grom_key_input_if.sv - grom8 CPU IO bus as seen by the key input peripheral
interface grom_key_input_if;
  logic [11:0] addr;
  logic        ioreq;
  logic        we;
  logic [7:0]  data_out;

  modport master (output addr, output ioreq, output we, input data_out);
  modport slave  (input addr, input ioreq, input we, output data_out);
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one-key 2-flop synchroniser plus stable/counting debounce FSM
module key_debounce
  import grom_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt;

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // FSM state, stability counter and accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end

  // Next state: any bounce back to the accepted level restarts the wait
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    case (state)
      ST_STABLE: begin
        if (s2 != level) begin
          state_nxt = ST_COUNTING;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_COUNTING: begin
        if (s2 == level) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          level_nxt = s2;
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
    // Edge strobes coincide with the edge that updates level
    rise = level_nxt & ~level;
    fall = ~level_nxt & level;
  end

endmodule

// File: rtl/grom_key_input.sv
// rtl/grom_key_input.sv - debounced key input IO peripheral; GROM_KEY_RELEASE_EVENTS_EN adds release flags
module grom_key_input
  import grom_io_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] i_keys,
  grom_key_input_if.slave     bus,
  output logic                o_irq
);

  logic [NUM_KEYS-1:0] level, rise, fall;
  logic [3:0]          level4, rise4, fall4;
  logic [3:0]          evt, evt_nxt;
  logic [3:0]          rel, rel_nxt;
  logic                rd, rd_events;
  logic [7:0]          status_byte, events_byte;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .key_raw(i_keys[k]),
      .level  (level[k]),
      .rise   (rise[k]),
      .fall   (fall[k])
    );
  end

  // Unpopulated key slots read as zero
  assign level4 = 4'(level);
  assign rise4  = 4'(rise);
  assign fall4  = 4'(fall);

  assign rd        = bus.ioreq & ~bus.we;
  assign rd_events = rd & (bus.addr[0] == REG_EVENTS);

  // Only addr[0] is decoded
  logic unused_addr;
  assign unused_addr = ^bus.addr[11:1];

`ifdef GROM_KEY_RELEASE_EVENTS_EN
  // Release flags: cleared by an EVENTS read, a same-edge release still sets
  always_comb begin
    rel_nxt = (rel & ~{4{rd_events}}) | fall4;
  end

  // Release flag register
  always_ff @(posedge clk) begin
    if (reset) rel <= 4'h0;
    else       rel <= rel_nxt;
  end
`else
  assign rel_nxt = 4'h0;
  assign rel     = 4'h0;
  logic unused_fall;
  assign unused_fall = ^fall4;
`endif

  // Press flags and read data: a same-edge press survives the clearing read
  always_comb begin
    evt_nxt = (evt & ~{4{rd_events}}) | rise4;
    status_byte = 8'h00;
    status_byte[STATUS_LEVEL_LSB +: 4] = level4;
    status_byte[STATUS_IRQ_BIT]        = |{evt, rel};
    events_byte = 8'h00;
    events_byte[EVENTS_PRESS_LSB +: 4] = evt;
    events_byte[EVENTS_REL_LSB +: 4]   = rel;
  end

  // Flags, interrupt and registered read data with RAM-like 1-cycle latency
  always_ff @(posedge clk) begin
    if (reset) begin
      evt          <= 4'h0;
      o_irq        <= 1'b0;
      bus.data_out <= 8'h00;
    end else begin
      evt   <= evt_nxt;
      o_irq <= |{evt_nxt, rel_nxt};
      if (rd) begin
        bus.data_out <= (bus.addr[0] == REG_EVENTS) ? events_byte : status_byte;
      end
    end
  end

endmodule

// File: tb/tb_grom_key_input.sv
// tb/tb_grom_key_input.sv - scoreboard bench for grom_key_input with DEBOUNCE_CYCLES=4
module tb_grom_key_input;
  import grom_io_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i_keys;
  logic       o_irq;
  logic [7:0] rd_data;
  logic [7:0] e;
  logic [7:0] sb[$];
  int         total = 0;
  int         bad = 0;

`ifdef GROM_KEY_RELEASE_EVENTS_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  grom_key_input_if bus ();

  grom_key_input #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .i_keys(i_keys),
    .bus   (bus),
    .o_irq (o_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic a, input logic [7:0] exp);
    bus.addr  = {11'd0, a};
    bus.we    = 1'b0;
    bus.ioreq = 1'b1;
    sb.push_back(exp);
    tick();
    bus.ioreq = 1'b0;
    rd_data   = bus.data_out;
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) e = 8'hxx;
    else e = sb.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1; i_keys = 4'h0;
    bus.addr = 12'd0; bus.ioreq = 1'b0; bus.we = 1'b0;
    repeat (3) tick();
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.data_out); end
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", o_irq); end
    reset = 1'b0;
    tick();
    do_read(REG_STATUS, 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL reset_status got=%h exp=%h", rd_data, e); end
    do_read(REG_EVENTS, 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL reset_events got=%h exp=%h", rd_data, e); end
  endtask

  task automatic test_press();
    i_keys[1] = 1'b1;
    repeat (5) tick();
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL press_early got=%b exp=0", o_irq); end
    tick();
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL press_at6 got=%b exp=1", o_irq); end
    do_read(REG_STATUS, 8'h82); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL press_status got=%h exp=%h", rd_data, e); end
    do_read(REG_EVENTS, 8'h02); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL press_events got=%h exp=%h", rd_data, e); end
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL press_irq_clr got=%b exp=0", o_irq); end
    do_read(REG_EVENTS, 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL press_events2 got=%h exp=%h", rd_data, e); end
  endtask

  task automatic test_bounce();
    i_keys[0] = 1'b1; tick();
    i_keys[0] = 1'b0; tick();
    i_keys[0] = 1'b1; tick(); tick();
    i_keys[0] = 1'b0;
    repeat (10) tick();
    do_read(REG_EVENTS, 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL bounce_events got=%h exp=%h", rd_data, e); end
    do_read(REG_STATUS, 8'h02); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL bounce_status got=%h exp=%h", rd_data, e); end
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL bounce_irq got=%b exp=0", o_irq); end
  endtask

  task automatic test_set_wins();
    i_keys[2] = 1'b1;
    repeat (5) tick();
    do_read(REG_EVENTS, 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL setwin_old got=%h exp=%h", rd_data, e); end
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL setwin_irq got=%b exp=1", o_irq); end
    do_read(REG_EVENTS, 8'h04); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL setwin_new got=%h exp=%h", rd_data, e); end
    i_keys = 4'h0;
    repeat (10) tick();
    do_read(REG_EVENTS, REL ? 8'h60 : 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL release_12 got=%h exp=%h", rd_data, e); end
    do_read(REG_EVENTS, 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL release_12_clr got=%h exp=%h", rd_data, e); end
  endtask

  task automatic test_io_write();
    i_keys[0] = 1'b1;
    repeat (8) tick();
    do_read(REG_STATUS, 8'h81); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL wr_pre_status got=%h exp=%h", rd_data, e); end
    bus.we = 1'b1; bus.ioreq = 1'b1;
    bus.addr = 12'd0; tick();
    bus.addr = 12'd1; tick();
    bus.ioreq = 1'b0; bus.we = 1'b0;
    total++; if (bus.data_out !== 8'h81) begin bad++; $display("FAIL wr_data got=%h exp=81", bus.data_out); end
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL wr_irq got=%b exp=1", o_irq); end
    do_read(REG_EVENTS, 8'h01); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL wr_events got=%h exp=%h", rd_data, e); end
    i_keys[0] = 1'b0;
    repeat (10) tick();
    do_read(REG_EVENTS, REL ? 8'h10 : 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL release_0 got=%h exp=%h", rd_data, e); end
  endtask

  task automatic test_reset_mid_debounce();
    i_keys[0] = 1'b1;
    repeat (8) tick();
    do_read(REG_STATUS, 8'h81); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL mid_pre_status got=%h exp=%h", rd_data, e); end
    i_keys[3] = 1'b1;
    repeat (4) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL mid_reset_data got=%h exp=00", bus.data_out); end
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq got=%b exp=0", o_irq); end
    repeat (5) tick();
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL mid_early got=%b exp=0", o_irq); end
    tick();
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL mid_at6 got=%b exp=1", o_irq); end
    do_read(REG_EVENTS, 8'h09); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL mid_events got=%h exp=%h", rd_data, e); end
    i_keys[0] = 1'b0;
    repeat (10) tick();
    do_read(REG_EVENTS, REL ? 8'h10 : 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL mid_rel0 got=%h exp=%h", rd_data, e); end
    i_keys[3] = 1'b0;
    repeat (10) tick();
    do_read(REG_EVENTS, REL ? 8'h80 : 8'h00); pop_exp();
    total++; if (rd_data !== e) begin bad++; $display("FAIL mid_rel3 got=%h exp=%h", rd_data, e); end
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL mid_final_irq got=%b exp=0", o_irq); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_set_wins();
    test_io_write();
    test_reset_mid_debounce();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
